uart_tx_peripheral: RTL and testbench
=====================================

UART_TX_PERIPHERAL -- requirements
Module: uart_tx_peripheral

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clock cycles per serial bit (legal range 2..65535).
REQ-002 Parameter TX_ADDRESS, default 32'd252: write address that enqueues one byte.
REQ-003 Parameter STATUS_ADDRESS, default 32'd253: read address that returns status.
REQ-004 clock  input  1: single clock; all state updates on the rising edge.
REQ-005 reset  input  1: synchronous, active-high; takes effect on the rising edge of clock.
REQ-006 mem_address  input  32: bus address, same bus as RAM, ROM and GPIO.
REQ-007 data_in  input  64: bus write data; only bits [7:0] are used.
REQ-008 mem_write_en  input  1: bus write strobe.
REQ-009 mem_read  input  1: bus read strobe.
REQ-010 data_out  output  64: read data; the top level drives it onto mem_data only while data_oe=1.
REQ-011 data_oe  output  1: read-data enable for the top-level tri-state driver.
REQ-012 tx  output  1: serial line; idle high; 8N1 frame, LSB first.
REQ-013 tx_busy  output  1: high while a frame is being shifted out.

Function
REQ-014 The block SHALL contain a 4-entry byte FIFO with write pointer, read pointer and count (0..4); pointers wrap from 3 to 0.
REQ-015 A rising edge with mem_write_en=1, mem_address=TX_ADDRESS and count<4 SHALL store data_in[7:0] at the write pointer and increment count.
REQ-016 A write to TX_ADDRESS with count=4 SHALL be dropped, leave the FIFO unchanged and set the sticky overflow flag, even if a pop occurs on the same edge.
REQ-017 Reads SHALL be combinational: data_oe=1 and data_out={60'b0, full, empty, tx_busy, overflow} while mem_read=1 and mem_address=STATUS_ADDRESS; otherwise data_oe=0 and data_out=0.
REQ-018 full SHALL equal (count==4); empty SHALL equal (count==0).
REQ-019 A rising edge during a status read SHALL clear overflow, except that a same-edge overflow event sets it (set wins).
REQ-020 Writes to STATUS_ADDRESS and reads of TX_ADDRESS SHALL have no effect; data_oe SHALL stay 0 for reads of TX_ADDRESS.
REQ-021 The FSM SHALL have four states: IDLE, START, DATA and STOP.
REQ-022 IDLE: if count>0, the block SHALL pop the head byte into the shift register, decrement count and enter START on that edge.
REQ-023 A push and a pop on the same edge SHALL leave count unchanged.
REQ-024 START SHALL hold tx=0 for CLKS_PER_BIT cycles and then enter DATA with bit index 0.
REQ-025 DATA SHALL hold tx=shift[bit index] for CLKS_PER_BIT cycles per bit, increment the index, and enter STOP after index 7.
REQ-026 STOP SHALL hold tx=1 for CLKS_PER_BIT cycles and then enter IDLE; back-to-back frames are therefore separated by exactly one idle clock.
REQ-027 A baud counter SHALL count 0..CLKS_PER_BIT-1 and restart at 0 on every state change.
REQ-028 tx SHALL be registered. Latency: a write at edge N is popped at edge N+1, and tx falls after edge N+1.
REQ-029 tx_busy SHALL be 1 in START, DATA and STOP, and 0 in IDLE.

Reset
REQ-030 On reset the block SHALL set: FSM to IDLE, tx=1, tx_busy=0, count=0, both pointers=0, overflow=0, baud counter=0 and bit index=0.
REQ-031 Reset asserted mid-frame SHALL abort the frame; tx=1 from the next edge, and FIFO contents are discarded.
REQ-032 Bus accesses in a cycle where reset=1 SHALL be ignored.

Verification
REQ-033 Write 8'hA5 to 252 with CLKS_PER_BIT=4 -> tx low for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4 cycles; tx_busy high for 40 cycles.
REQ-034 Write 6 bytes on 6 consecutive cycles while idle -> 5 bytes transmitted in order (the first is popped immediately and one write is dropped); status read returns overflow=1 and the following read returns overflow=0.
REQ-035 Read 253 after reset -> data_oe=1, data_out=64'h4 (empty=1); reading address 252 or 100 -> data_oe=0, data_out=0.
REQ-036 Fill the FIFO to 4 during a frame, then write on the edge where IDLE pops -> write dropped, overflow=1, count stays 3.
REQ-037 Assert reset during bit 3 of a frame -> tx=1 and tx_busy=0 after that edge, status=64'h4, and no further frames are sent.
REQ-038 Two queued bytes -> the stop bit of the first frame is followed by exactly 1 idle-high clock before the next start bit.

Source files
------------

// File: rtl/uart_tx_peripheral.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_peripheral
//  Purpose  : Memory-mapped 8N1 UART transmitter with 4-entry byte FIFO
//  Revision : 1.0
// ============================================================================
module uart_tx_peripheral #(
   parameter int          CLKS_PER_BIT   = 16,
   parameter logic [31:0] TX_ADDRESS     = 32'd252,
   parameter logic [31:0] STATUS_ADDRESS = 32'd253
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] mem_address,
   input  logic [63:0] data_in,
   input  logic        mem_write_en,
   input  logic        mem_read,
   output logic [63:0] data_out,
   output logic        data_oe,
   output logic        tx,
   output logic        tx_busy
);

   localparam logic [1:0]  c_IDLE      = 2'd0;
   localparam logic [1:0]  c_START     = 2'd1;
   localparam logic [1:0]  c_DATA      = 2'd2;
   localparam logic [1:0]  c_STOP      = 2'd3;
   localparam logic [15:0] c_BAUD_LAST = 16'(CLKS_PER_BIT - 1);

   logic [1:0]  r_state;
   logic [15:0] r_baud;
   logic [2:0]  r_bit;
   logic [7:0]  r_shift;
   logic        r_tx;
   logic [7:0]  r_fifo [4];
   logic [1:0]  r_wr_ptr;
   logic [1:0]  r_rd_ptr;
   logic [2:0]  r_count;
   logic        r_overflow;

   logic [1:0]  w_state_next;
   logic [15:0] w_baud_next;
   logic [2:0]  w_bit_next;
   logic        w_tx_next;
   logic        w_baud_done;
   logic        w_push_req;
   logic        w_push;
   logic        w_ovf_evt;
   logic        w_pop;
   logic        w_status_rd;
   logic        w_full;
   logic        w_empty;
   logic        w_unused;

   assign w_unused    = ^data_in[63:8];
   assign w_full      = (r_count == 3'd4);
   assign w_empty     = (r_count == 3'd0);
   assign w_push_req  = mem_write_en && (mem_address == TX_ADDRESS);
   assign w_push      = w_push_req && !w_full;
   // A full-FIFO write is dropped even when IDLE frees a slot on the same edge.
   assign w_ovf_evt   = w_push_req && w_full;
   assign w_pop       = (r_state == c_IDLE) && !w_empty;
   assign w_status_rd = mem_read && (mem_address == STATUS_ADDRESS);
   assign w_baud_done = (r_baud == c_BAUD_LAST);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= c_IDLE;
         r_baud     <= 16'd0;
         r_bit      <= 3'd0;
         r_shift    <= 8'd0;
         r_tx       <= 1'b1;
         r_wr_ptr   <= 2'd0;
         r_rd_ptr   <= 2'd0;
         r_count    <= 3'd0;
         r_overflow <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_baud  <= w_baud_next;
         r_bit   <= w_bit_next;
         r_tx    <= w_tx_next;
         if (w_push) begin
            r_fifo[r_wr_ptr] <= data_in[7:0];
            r_wr_ptr         <= r_wr_ptr + 2'd1;
         end
         if (w_pop) begin
            r_shift  <= r_fifo[r_rd_ptr];
            r_rd_ptr <= r_rd_ptr + 2'd1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 3'd1;
            2'b01:   r_count <= r_count - 3'd1;
            default: r_count <= r_count;
         endcase
         if (w_ovf_evt) begin
            r_overflow <= 1'b1;
         end else if (w_status_rd) begin
            r_overflow <= 1'b0;
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_baud_next  = r_baud + 16'd1;
      w_bit_next   = r_bit;
      case (r_state)
         c_IDLE: begin
            w_baud_next = 16'd0;
            w_bit_next  = 3'd0;
            if (w_pop) begin
               w_state_next = c_START;
            end
         end
         c_START: begin
            if (w_baud_done) begin
               w_state_next = c_DATA;
               w_baud_next  = 16'd0;
               w_bit_next   = 3'd0;
            end
         end
         c_DATA: begin
            if (w_baud_done) begin
               w_baud_next = 16'd0;
               if (r_bit == 3'd7) begin
                  w_state_next = c_STOP;
               end else begin
                  w_bit_next = r_bit + 3'd1;
               end
            end
         end
         default: begin
            if (w_baud_done) begin
               w_state_next = c_IDLE;
               w_baud_next  = 16'd0;
            end
         end
      endcase
   end

   // tx is registered from the next state so the line changes on the same edge as the FSM.
   always_comb begin
      w_tx_next = 1'b1;
      case (w_state_next)
         c_START: w_tx_next = 1'b0;
         c_DATA:  w_tx_next = r_shift[w_bit_next];
         default: w_tx_next = 1'b1;
      endcase
      tx      = r_tx;
      tx_busy = (r_state != c_IDLE);
      data_oe = w_status_rd;
      if (w_status_rd) begin
         data_out = {60'd0, w_full, w_empty, tx_busy, r_overflow};
      end else begin
         data_out = 64'd0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_peripheral.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_peripheral
//  Purpose  : Directed self-checking bench for uart_tx_peripheral (CLKS_PER_BIT=4)
//  Revision : 1.0
// ============================================================================
module tb_uart_tx_peripheral;

   localparam int c_CPB = 4;

   logic        clock;
   logic        reset;
   logic [31:0] mem_address;
   logic [63:0] data_in;
   logic        mem_write_en;
   logic        mem_read;
   logic [63:0] data_out;
   logic        data_oe;
   logic        tx;
   logic        tx_busy;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [31:0] addr;
      logic        rd;
      logic        wr;
      logic [63:0] din;
      logic        exp_oe;
      logic [63:0] exp_data;
   } vec_t;

   vec_t vecs [6];

   uart_tx_peripheral #(
      .CLKS_PER_BIT  (c_CPB),
      .TX_ADDRESS    (32'd252),
      .STATUS_ADDRESS(32'd253)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .mem_address (mem_address),
      .data_in     (data_in),
      .mem_write_en(mem_write_en),
      .mem_read    (mem_read),
      .data_out    (data_out),
      .data_oe     (data_oe),
      .tx          (tx),
      .tx_busy     (tx_busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic bus_write(input logic [31:0] addr, input logic [7:0] b);
      mem_address  = addr;
      data_in      = {56'hDEAD_BEEF_0000_00, b};
      mem_write_en = 1'b1;
      tick();
      mem_write_en = 1'b0;
      mem_address  = 32'd0;
      data_in      = 64'd0;
   endtask

   // Combinational status read; optionally held across one edge to clear overflow.
   task automatic status_read(input string name, input logic [63:0] exp, input bit hold_edge);
      mem_address = 32'd253;
      mem_read    = 1'b1;
      #1;
      chk({name, "_oe"}, 64'(data_oe), 64'd1);
      chk(name, data_out, exp);
      if (hold_edge) begin
         @(posedge clock);
         #1;
      end
      mem_read    = 1'b0;
      mem_address = 32'd0;
   endtask

   // Entered #1 after the edge that started the frame (or 'off' cycles later).
   task automatic check_frame(input string name, input logic [7:0] b, input int off);
      logic [9:0] fr;
      fr = {1'b1, b, 1'b0};
      for (int c = off; c < 10 * c_CPB; c++) begin
         chk({name, "_tx"}, 64'(tx), 64'(fr[c / c_CPB]));
         chk({name, "_busy"}, 64'(tx_busy), 64'd1);
         tick();
      end
      chk({name, "_end_tx"}, 64'(tx), 64'd1);
      chk({name, "_end_busy"}, 64'(tx_busy), 64'd0);
   endtask

   initial begin
      logic [7:0] bytes6 [6];
      logic [7:0] fill   [6];
      int         lows;

      reset        = 1'b1;
      mem_address  = 32'd0;
      data_in      = 64'd0;
      mem_write_en = 1'b0;
      mem_read     = 1'b0;
      tick();
      tick();
      reset = 1'b0;

      // Reset state
      chk("reset_tx", 64'(tx), 64'd1);
      chk("reset_busy", 64'(tx_busy), 64'd0);
      status_read("reset_status", 64'h4, 1'b0);

      // Address decode table: reads of TX and other addresses, writes to STATUS
      vecs[0] = '{32'd253, 1'b1, 1'b0, 64'd0,    1'b1, 64'h4};
      vecs[1] = '{32'd252, 1'b1, 1'b0, 64'd0,    1'b0, 64'h0};
      vecs[2] = '{32'd100, 1'b1, 1'b0, 64'd0,    1'b0, 64'h0};
      vecs[3] = '{32'd253, 1'b0, 1'b0, 64'd0,    1'b0, 64'h0};
      vecs[4] = '{32'd253, 1'b0, 1'b1, 64'h5A,   1'b0, 64'h0};
      vecs[5] = '{32'd254, 1'b1, 1'b1, 64'h77,   1'b0, 64'h0};
      for (int i = 0; i < 6; i++) begin
         mem_address  = vecs[i].addr;
         mem_read     = vecs[i].rd;
         mem_write_en = vecs[i].wr;
         data_in      = vecs[i].din;
         #1;
         chk($sformatf("vec%0d_oe", i), 64'(data_oe), 64'(vecs[i].exp_oe));
         chk($sformatf("vec%0d_data", i), data_out, vecs[i].exp_data);
         tick();
      end
      mem_read = 1'b0; mem_write_en = 1'b0; mem_address = 32'd0; data_in = 64'd0;
      tick();
      tick();
      chk("nowrite_tx", 64'(tx), 64'd1);
      chk("nowrite_busy", 64'(tx_busy), 64'd0);
      status_read("nowrite_status", 64'h4, 1'b0);

      // Single frame 8'hA5: popped on the edge after the write
      bus_write(32'd252, 8'hA5);
      chk("a5_pre_tx", 64'(tx), 64'd1);
      tick();
      check_frame("a5", 8'hA5, 0);

      // Six consecutive writes: first pops immediately, sixth is dropped
      bytes6 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      for (int i = 0; i < 6; i++) bus_write(32'd252, bytes6[i]);
      status_read("burst_status_ovf", 64'hB, 1'b1);
      status_read("burst_status_clr", 64'hA, 1'b0);
      check_frame("burst0", bytes6[0], 5);
      for (int i = 1; i < 5; i++) begin
         tick();
         chk($sformatf("burst%0d_start", i), 64'(tx), 64'd0);
         check_frame($sformatf("burst%0d", i), bytes6[i], 0);
      end
      lows = 0;
      for (int i = 0; i < 50; i++) begin
         if (tx !== 1'b1) lows++;
         tick();
      end
      chk("burst_no_sixth", 64'(lows), 64'd0);
      status_read("burst_final_status", 64'h4, 1'b0);

      // Back-to-back frames separated by exactly one idle clock
      bus_write(32'd252, 8'h3C);
      bus_write(32'd252, 8'hC3);
      check_frame("b2b0", 8'h3C, 0);
      tick();
      chk("b2b_gap_start_tx", 64'(tx), 64'd0);
      check_frame("b2b1", 8'hC3, 0);

      // Full FIFO write on the same edge that IDLE pops: dropped, count stays 3
      fill = '{8'h81, 8'h42, 8'h24, 8'h18, 8'hF0, 8'h0F};
      bus_write(32'd252, fill[0]);
      tick();
      for (int i = 1; i < 5; i++) bus_write(32'd252, fill[i]);
      status_read("fill_full", 64'hA, 1'b0);
      check_frame("fill0", fill[0], 4);
      bus_write(32'd252, fill[5]);
      status_read("fill_popdrop", 64'h3, 1'b0);
      check_frame("fill1", fill[1], 0);
      for (int i = 2; i < 5; i++) begin
         tick();
         check_frame($sformatf("fill%0d", i), fill[i], 0);
      end
      lows = 0;
      for (int i = 0; i < 50; i++) begin
         if (tx !== 1'b1) lows++;
         tick();
      end
      chk("fill_dropped_not_sent", 64'(lows), 64'd0);
      status_read("fill_sticky", 64'h5, 1'b1);
      status_read("fill_cleared", 64'h4, 1'b0);

      // Reset during data bit 3 aborts the frame; bus writes during reset are ignored
      bus_write(32'd252, 8'h37);
      bus_write(32'd252, 8'h99);
      for (int i = 0; i < 4 * c_CPB + 1; i++) tick();
      chk("abort_bit3_tx", 64'(tx), 64'd0);
      chk("abort_bit3_busy", 64'(tx_busy), 64'd1);
      reset        = 1'b1;
      mem_address  = 32'd252;
      data_in      = 64'h66;
      mem_write_en = 1'b1;
      tick();
      reset        = 1'b0;
      mem_write_en = 1'b0;
      mem_address  = 32'd0;
      chk("abort_tx", 64'(tx), 64'd1);
      chk("abort_busy", 64'(tx_busy), 64'd0);
      status_read("abort_status", 64'h4, 1'b0);
      lows = 0;
      for (int i = 0; i < 60; i++) begin
         if (tx !== 1'b1 || tx_busy !== 1'b0) lows++;
         tick();
      end
      chk("abort_no_frames", 64'(lows), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
